mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter parallelism, default 8, operand width in bits.
REQ-002 SHALL have parameter ARCH_TYPE, default 2, architecture select passed unchanged to the shared multiplier.
REQ-003 SHALL have port clk  input  1  single clock; all state rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  requester has an operand pair.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  operands accepted this cycle.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  parallelism  unsigned operands.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port out_product  output  2*parallelism  unsigned product.
REQ-011 SHALL have port out_id  output  1  requester index of out_product.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM IDLE -> LOAD -> DONE -> IDLE (plus STAGE between LOAD and DONE when REQ-026 applies).
REQ-014 In IDLE, SHALL assert ready combinationally only to the granted requester; all other ready outputs low in every state.
REQ-015 Grant: only one valid -> that one; both valid -> the requester not granted last (round-robin); last-grant pointer resets to 1 so req0 wins first contention.
REQ-016 On valid&ready, SHALL latch both operands and the requester index, update last-grant, go to LOAD.
REQ-017 In LOAD, latched operands drive the multiplier; at the clock edge ending LOAD, product is registered into out_product, out_id set, go to DONE.
REQ-018 Latency without pipeline option: accept at edge N, out_valid high from edge N+2.
REQ-019 In DONE, out_valid high, out_product/out_id stable until out_valid&out_ready; then IDLE, out_valid low next cycle.
REQ-020 No accept in the same cycle as a result handshake; sustained throughput one result per 3 cycles (4 with REQ-026).
REQ-021 Product SHALL be full-width unsigned a*b, no truncation or overflow.
REQ-022 A valid deasserted before handshake SHALL be ignored, no state change; inputs outside IDLE have no effect.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, out_valid=0, out_product=0, out_id=0, busy=0, ready outputs=0, last-grant=1.
REQ-024 Reset mid-operation SHALL discard in-flight operands and results; first cycle after release behaves as fresh IDLE.

Configuration
REQ-025 SHALL use macro MULT_ARBITER_PIPE_EN.
REQ-026 Defined: extra STAGE state registers the raw multiplier output before the out_product register; latency accept-edge N to out_valid at N+3.
REQ-027 Undefined: no STAGE state or register; latency per REQ-018; functional results identical.

Structure
REQ-028 Shared package mult_pkg SHALL hold the FSM state enum (IDLE, LOAD, STAGE, DONE) and the ARCH_TYPE encoding constants.
REQ-029 SHALL instantiate exactly one sub-module, the existing multiplier, with .parallelism and .ARCH_TYPE forwarded; no other arithmetic.

Verification
REQ-030 req0 only, a=0x11 b=0x11, out_ready=1 -> out_valid at N+2, out_product=0x0121, out_id=0.
REQ-031 Both valid from reset, req0 0x11*0x11, req1 0xFF*0xFF -> results 0x0121 id 0 then 0xFE01 id 1; req1 ready never high in the first IDLE.
REQ-032 out_ready held low 10 cycles in DONE -> out_product/out_id stable, req ready low, busy high; release -> IDLE next cycle.
REQ-033 rst_n pulsed low in LOAD with 0x0F*0x0F -> out_valid never asserts, busy=0, next request 0x02*0x03 -> 0x0006.
REQ-034 Build with MULT_ARBITER_PIPE_EN, 0xFF*0x01 -> out_valid at N+3, out_product=0x00FF.
REQ-035 Both requesters continuously valid 6 transactions -> ids alternate 0,1,0,1,0,1, one result per 3 cycles.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier arbiter and its multiplier.
//   state_t     : arbiter FSM states (STAGE exists only in pipelined builds)
//   ARCH_*      : multiplier architecture select encodings
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STAGE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int ARCH_BEHAV     = 0;  // single '*' operator
  localparam int ARCH_SHIFT_ADD = 1;  // loop-accumulated partial products
  localparam int ARCH_ARRAY     = 2;  // explicit adder chain of partial products

endpackage

// File: rtl/mult_arbiter_mult.sv
// Combinational unsigned multiplier shared by the arbiter.
// Parameters:
//   parallelism : operand width in bits
//   ARCH_TYPE   : implementation style (ARCH_BEHAV / ARCH_SHIFT_ADD / ARCH_ARRAY)
// Ports:
//   a, b : parallelism-bit unsigned operands
//   p    : 2*parallelism-bit full-width product
module mult_arbiter_mult
  import mult_pkg::*;
#(
  parameter int parallelism = 8,
  parameter int ARCH_TYPE   = ARCH_ARRAY
) (
  input  logic [parallelism-1:0]   a,
  input  logic [parallelism-1:0]   b,
  output logic [2*parallelism-1:0] p
);

  logic [2*parallelism-1:0] ax;
  logic [2*parallelism-1:0] bx;

  assign ax = {{parallelism{1'b0}}, a};
  assign bx = {{parallelism{1'b0}}, b};

  generate
    if (ARCH_TYPE == ARCH_BEHAV) begin : g_behav
      assign p = ax * bx;
    end else if (ARCH_TYPE == ARCH_SHIFT_ADD) begin : g_shift_add
      logic [2*parallelism-1:0] acc;
      always_comb begin
        acc = '0;
        for (int i = 0; i < parallelism; i++) begin
          if (b[i]) acc = acc + (ax << i);
        end
        p = acc;
      end
    end else begin : g_array
      // row[i] holds the sum of the first i partial products
      logic [2*parallelism-1:0] row [parallelism+1];
      assign row[0] = '0;
      for (genvar i = 0; i < parallelism; i++) begin : g_row
        assign row[i+1] = row[i] + (b[i] ? (ax << i) : '0);
      end
      assign p = row[parallelism];
    end
  endgenerate

endmodule

// File: rtl/mult_arbiter.sv
// Two-requester round-robin arbiter in front of one shared multiplier.
// A requester's operand pair is accepted in IDLE, multiplied in LOAD and
// presented in DONE until the consumer takes it.
// Build option: define MULT_ARBITER_PIPE_EN to insert a STAGE state that
// registers the raw multiplier output before out_product (one extra cycle).
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   reqN_valid / reqN_ready  : operand handshake for requester N (0/1)
//   reqN_a, reqN_b           : unsigned operands of requester N
//   out_valid / out_ready    : result handshake
//   out_product, out_id      : full-width product and originating requester
//   busy                     : high whenever the FSM is not in IDLE
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int parallelism = 8,
  parameter int ARCH_TYPE   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  input  logic                     req1_valid,
  output logic                     req0_ready,
  output logic                     req1_ready,
  input  logic [parallelism-1:0]   req0_a,
  input  logic [parallelism-1:0]   req0_b,
  input  logic [parallelism-1:0]   req1_a,
  input  logic [parallelism-1:0]   req1_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*parallelism-1:0] out_product,
  output logic                     out_id,
  output logic                     busy
);

  state_t                   state_q;
  state_t                   state_d;
  logic                     last_q;   // 1: requester 1 was granted last
  logic                     grant1;
  logic                     accept;
  logic [parallelism-1:0]   a_p0;
  logic [parallelism-1:0]   b_p0;
  logic                     id_p0;
  logic [2*parallelism-1:0] prod;
`ifdef MULT_ARBITER_PIPE_EN
  logic [2*parallelism-1:0] prod_p1;
`endif

  // Requester 1 wins when it is alone or when requester 0 had the last grant.
  assign grant1 = req1_valid && (!req0_valid || !last_q);
  assign busy   = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        // rst_n gating keeps ready low while reset is held
        if (rst_n && (req0_valid || req1_valid)) begin
          accept     = 1'b1;
          req0_ready = !grant1;
          req1_ready = grant1;
          state_d    = LOAD;
        end
      end
`ifdef MULT_ARBITER_PIPE_EN
      LOAD:    state_d = STAGE;
      STAGE:   state_d = DONE;
`else
      LOAD:    state_d = DONE;
`endif
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= 1'b1;
      out_product <= '0;
      out_id      <= 1'b0;
    end else begin
      if (accept) last_q <= grant1;
`ifdef MULT_ARBITER_PIPE_EN
      if (state_q == STAGE) begin
        out_product <= prod_p1;
        out_id      <= id_p0;
      end
`else
      if (state_q == LOAD) begin
        out_product <= prod;
        out_id      <= id_p0;
      end
`endif
    end
  end

  // Stage p0: operand capture on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0  <= grant1 ? req1_a : req0_a;
      b_p0  <= grant1 ? req1_b : req0_b;
      id_p0 <= grant1;
    end
  end

  mult_arbiter_mult #(
    .parallelism (parallelism),
    .ARCH_TYPE   (ARCH_TYPE)
  ) u_mult (
    .a (a_p0),
    .b (b_p0),
    .p (prod)
  );

`ifdef MULT_ARBITER_PIPE_EN
  // Stage p1: raw multiplier output registered during LOAD
  always_ff @(posedge clk) begin
    if (state_q == LOAD) prod_p1 <= prod;
  end
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Testbench for mult_arbiter: directed scenarios plus randomized traffic,
// all checked against a transaction-level reference model.
module tb_mult_arbiter;

  localparam int P = 8;
`ifdef MULT_ARBITER_PIPE_EN
  localparam int EXP_LAT = 3;   // accept edge N -> out_valid sampled at N+3
`else
  localparam int EXP_LAT = 2;   // accept edge N -> out_valid sampled at N+2
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req0_valid, req1_valid;
  logic           req0_ready, req1_ready;
  logic [P-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic           out_valid, out_ready;
  logic [2*P-1:0] out_product;
  logic           out_id;
  logic           busy;

  always #5 clk = ~clk;

  mult_arbiter #(.parallelism(P), .ARCH_TYPE(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req1_valid  (req1_valid),
    .req0_ready  (req0_ready),
    .req1_ready  (req1_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_id      (out_id),
    .busy        (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: a pending-result queue plus busy/elapsed bookkeeping.
  typedef struct {
    logic           id;
    logic [2*P-1:0] p;
  } exp_t;

  exp_t           q[$];
  bit             m_busy;
  int             m_cnt;
  bit             m_last;      // 1: requester 1 was granted last
  int             cyc;
  int             n_acc, n_pop;
  int             acc_cyc, meas_lat;
  bit             ov_prev;
  bit             acc_last0, acc_last1, auto_drop;
  logic [2*P-1:0] rec_p[$];
  logic           rec_id[$];
  int             rec_cyc[$];

  task automatic model_reset();
    q.delete();
    m_busy  = 1'b0;
    m_cnt   = 0;
    m_last  = 1'b1;
    ov_prev = 1'b0;
  endtask

  task automatic model_eval();
    bit   g0, g1, eov;
    exp_t e;
    eov = m_busy && (m_cnt >= EXP_LAT - 1);
    g0  = !m_busy && req0_valid && (!req1_valid || m_last);
    g1  = !m_busy && req1_valid && (!req0_valid || !m_last);
    check("req0_ready", req0_ready, g0);
    check("req1_ready", req1_ready, g1);
    check("busy", busy, m_busy);
    check("out_valid", out_valid, eov);
    if (eov && q.size() > 0) begin
      check("out_product", out_product, q[0].p);
      check("out_id", out_id, q[0].id);
    end
    if (out_valid && !ov_prev) meas_lat = cyc - acc_cyc;
    ov_prev = out_valid;
    if (g0 || g1) begin
      e.id = g1;
      e.p  = g1 ? (2*P)'(req1_a) * (2*P)'(req1_b) : (2*P)'(req0_a) * (2*P)'(req0_b);
      q.push_back(e);
      m_last    = g1;
      m_busy    = 1'b1;
      m_cnt     = 0;
      acc_cyc   = cyc;
      acc_last0 = g0;
      acc_last1 = g1;
      n_acc++;
    end else if (m_busy) begin
      if (eov && out_ready) begin
        rec_p.push_back(out_product);
        rec_id.push_back(out_id);
        rec_cyc.push_back(cyc);
        if (q.size() > 0) void'(q.pop_front());
        m_busy = 1'b0;
        n_pop++;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (rst_n) model_eval();
    @(posedge clk);
    #1;
    cyc++;
    if (auto_drop) begin
      if (acc_last0) req0_valid = 1'b0;
      if (acc_last1) req1_valid = 1'b0;
    end
    acc_last0 = 1'b0;
    acc_last1 = 1'b0;
  endtask

  task automatic do_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rst_n      = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", out_product, 0);
    check("rst_id", out_id, 0);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    model_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_acc(input int limit);
    int start = n_acc;
    for (int i = 0; i < limit && n_acc == start; i++) step();
    check("accept_timeout", n_acc, start + 1);
  endtask

  task automatic run_pops(input int n, input int limit);
    int start = n_pop;
    for (int i = 0; i < limit && n_pop < start + n; i++) step();
    check("result_timeout", n_pop, start + n);
  endtask

  function automatic logic [P-1:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return P'($urandom);
    endcase
  endfunction

  initial begin
    cyc = 0; n_acc = 0; n_pop = 0; acc_cyc = 0; meas_lat = 0;
    acc_last0 = 0; acc_last1 = 0; auto_drop = 1;
    req0_a = 8'h5A; req0_b = 8'hA5; req1_a = 8'h33; req1_b = 8'hCC;
    out_ready = 1'b1;
    model_reset();
    #2;
    do_reset();

    // req0 alone: 0x11 * 0x11
    req1_valid = 0;
    req0_valid = 1; req0_a = 8'h11; req0_b = 8'h11;
    run_pops(1, 20);
    check("t030_prod", rec_p[$], 16'h0121);
    check("t030_id", rec_id[$], 0);
    check("t030_lat", meas_lat, EXP_LAT);

    // contention straight out of reset
    do_reset();
    req0_a = 8'h11; req0_b = 8'h11; req1_a = 8'hFF; req1_b = 8'hFF;
    rec_p.delete(); rec_id.delete(); rec_cyc.delete();
    run_pops(2, 30);
    if (rec_p.size() == 2) begin
      check("t031_prod0", rec_p[0], 16'h0121);
      check("t031_id0", rec_id[0], 0);
      check("t031_prod1", rec_p[1], 16'hFE01);
      check("t031_id1", rec_id[1], 1);
    end else check("t031_count", rec_p.size(), 2);
    req0_valid = 0; req1_valid = 0;

    // back-pressure in DONE; a request during it must be ignored
    out_ready = 0;
    req0_valid = 1; req0_a = 8'h12; req0_b = 8'h34;
    wait_acc(10);
    req1_valid = 1; req1_a = 8'h07; req1_b = 8'h09;
    for (int i = 0; i < EXP_LAT - 1 + 10; i++) step();
    check("t032_busy", busy, 1);
    check("t032_valid", out_valid, 1);
    check("t032_prod", out_product, 16'h03A8);
    check("t032_id", out_id, 0);
    check("t032_ready1", req1_ready, 0);
    out_ready = 1;
    step();
    check("t032_idle", busy, 0);
    run_pops(1, 20);
    check("t032_req1_prod", rec_p[$], 16'h003F);

    // reset while in LOAD discards the operation
    req0_valid = 1; req1_valid = 0; req0_a = 8'h0F; req0_b = 8'h0F;
    wait_acc(10);
    check("t033_load_busy", busy, 1);
    do_reset();
    req1_valid = 0;
    req0_a = 8'h02; req0_b = 8'h03;
    run_pops(1, 20);
    check("t033_prod", rec_p[$], 16'h0006);
    check("t033_id", rec_id[$], 0);

    // latency with a 0xFF * 0x01 operand pair
    req0_valid = 1; req0_a = 8'hFF; req0_b = 8'h01;
    run_pops(1, 20);
    check("t034_prod", rec_p[$], 16'h00FF);
    check("t034_lat", meas_lat, EXP_LAT);

    // both requesters continuously valid: strict alternation
    do_reset();
    auto_drop = 0;
    req0_a = 8'h21; req0_b = 8'h43; req1_a = 8'h65; req1_b = 8'h87;
    rec_p.delete(); rec_id.delete(); rec_cyc.delete();
    run_pops(6, 60);
    req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < rec_id.size(); i++) begin
      check("t035_id", rec_id[i], i % 2);
      if (i > 0) check("t035_spacing", rec_cyc[i] - rec_cyc[i-1], EXP_LAT + 1);
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_a = rnd_op(); req0_b = rnd_op();
      req1_a = rnd_op(); req1_b = rnd_op();
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    req0_valid = 0; req1_valid = 0; out_ready = 1;
    for (int i = 0; i < 10; i++) step();
    check("drain_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
